// File: rtl/fll_ser_pkg.sv
// Shared types and helpers for the fll width-down serializer.
package fll_ser_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } fll_state_e;

   // Lowest bit of beat 'idx' inside a word of 'nb' slices of 'sw' bits; ord=1 walks MSB first.
   function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned nb,
                                            input int unsigned sw, input bit ord);
      return (ord ? (nb - 32'd1 - idx) : idx) * sw;
   endfunction

endpackage

// File: rtl/fll_ser_if.sv
// Wide input stream and narrow output stream of the fll serializer.
interface fll_ser_if #(
   parameter int unsigned DW = 32,
   parameter int unsigned SW = 8
);
   localparam int unsigned LW = $clog2(DW / SW);

   logic [DW-1:0] ffi_bus;
   logic [LW-1:0] ffi_len;
   logic          ffi_vld;
   logic          ffi_rdy;
   logic [SW-1:0] ffo_bus;
   logic          ffo_lst;
   logic          ffo_vld;
   logic          ffo_rdy;

   modport slave (
      input  ffi_bus, ffi_len, ffi_vld, ffo_rdy,
      output ffi_rdy, ffo_bus, ffo_lst, ffo_vld
   );

   modport master (
      output ffi_bus, ffi_len, ffi_vld, ffo_rdy,
      input  ffi_rdy, ffo_bus, ffo_lst, ffo_vld
   );

endinterface

// File: rtl/fll_ser.sv
// Width-down serializer: one DW-bit word in, up to DW/SW SW-bit beats out, last beat flagged.
// One word shifts out while a second is held, so the output sustains a beat every clock.
module fll_ser
   import fll_ser_pkg::*;
#(
   parameter int unsigned DW  = 32,
   parameter int unsigned SW  = 8,
   parameter bit          ORD = 1'b0
) (
   input logic      ff_clk,
   input logic      ff_rst,
   fll_ser_if.slave bus_if
);

   localparam int unsigned NB = DW / SW;
   localparam int unsigned LW = $clog2(NB);

   fll_state_e    state;
   logic [DW-1:0] sft_dat;
   logic [LW-1:0] sft_len;
   logic [LW-1:0] sft_cnt;
   logic [DW-1:0] hld_dat;
   logic [LW-1:0] hld_len;

   logic          ffi_trn;
   logic          ffo_trn;
   logic          lst_trn;
   logic          ld_ffi;
   logic          ld_sft_hld;
   logic          ld_hld;
   logic          adv;
   logic          go_empty;
   logic [LW-1:0] cnt_inc;

   assign ffi_trn    = bus_if.ffi_vld & bus_if.ffi_rdy;
   assign ffo_trn    = bus_if.ffo_vld & bus_if.ffo_rdy;
   assign lst_trn    = ffo_trn & bus_if.ffo_lst;
   assign cnt_inc    = sft_cnt + LW'(1);

   // Datapath actions decoded from state and the two handshakes.
   assign ld_ffi     = ffi_trn & ((state == ST_EMPTY) | ((state == ST_BUSY) & lst_trn));
   assign ld_sft_hld = (state == ST_FULL) & lst_trn;
   assign ld_hld     = ffi_trn & (state == ST_BUSY) & ~lst_trn;
   assign adv        = ffo_trn & ~bus_if.ffo_lst;
   assign go_empty   = (state == ST_BUSY) & lst_trn & ~ffi_trn;

   // Occupancy FSM; ready and valid are registered alongside the state.
   always_ff @(posedge ff_clk or posedge ff_rst) begin
      if (ff_rst) begin
         state          <= ST_EMPTY;
         bus_if.ffi_rdy <= 1'b1;
         bus_if.ffo_vld <= 1'b0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (ffi_trn) begin
                  state          <= ST_BUSY;
                  bus_if.ffo_vld <= 1'b1;
               end
            end
            ST_BUSY: begin
               if (ffi_trn && !lst_trn) begin
                  state          <= ST_FULL;
                  bus_if.ffi_rdy <= 1'b0;
               end else if (!ffi_trn && lst_trn) begin
                  state          <= ST_EMPTY;
                  bus_if.ffo_vld <= 1'b0;
               end
            end
            ST_FULL: begin
               if (lst_trn) begin
                  state          <= ST_BUSY;
                  bus_if.ffi_rdy <= 1'b1;
               end
            end
            default: begin
               state          <= ST_EMPTY;
               bus_if.ffi_rdy <= 1'b1;
               bus_if.ffo_vld <= 1'b0;
            end
         endcase
      end
   end

   // Shift/hold registers; the output beat is pre-selected from whatever becomes current next.
   always_ff @(posedge ff_clk or posedge ff_rst) begin
      if (ff_rst) begin
         sft_dat        <= '0;
         sft_len        <= '0;
         sft_cnt        <= '0;
         hld_dat        <= '0;
         hld_len        <= '0;
         bus_if.ffo_bus <= '0;
         bus_if.ffo_lst <= 1'b0;
      end else begin
         if (ld_ffi) begin
            sft_dat        <= bus_if.ffi_bus;
            sft_len        <= bus_if.ffi_len;
            sft_cnt        <= '0;
            bus_if.ffo_bus <= bus_if.ffi_bus[slice_lo(32'd0, NB, SW, ORD) +: SW];
            bus_if.ffo_lst <= (bus_if.ffi_len == '0);
         end else if (ld_sft_hld) begin
            sft_dat        <= hld_dat;
            sft_len        <= hld_len;
            sft_cnt        <= '0;
            bus_if.ffo_bus <= hld_dat[slice_lo(32'd0, NB, SW, ORD) +: SW];
            bus_if.ffo_lst <= (hld_len == '0);
         end else if (adv) begin
            sft_cnt        <= cnt_inc;
            bus_if.ffo_bus <= sft_dat[slice_lo(32'(cnt_inc), NB, SW, ORD) +: SW];
            bus_if.ffo_lst <= (cnt_inc == sft_len);
         end else if (go_empty) begin
            bus_if.ffo_lst <= 1'b0;
         end

         if (ld_hld) begin
            hld_dat <= bus_if.ffi_bus;
            hld_len <= bus_if.ffi_len;
         end
      end
   end

endmodule
